// File: rtl/timer_evt_pkg.sv
// Shared definitions for the timer event controller.
//   - APB register offsets (PADDR[3:0])
//   - CTRL register bit positions
//   - Service FSM state encoding
package timer_evt_pkg;

    localparam logic [3:0] REG_MASK = 4'h0;
    localparam logic [3:0] REG_PEND = 4'h4;
    localparam logic [3:0] REG_CTRL = 4'h8;
    localparam logic [3:0] REG_ID   = 4'hC;

    localparam int CTRL_EN_BIT = 0;
    localparam int CTRL_RR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } evt_state_e;

endpackage

// File: rtl/evt_rr_arbiter.sv
// Combinational event picker.
//   req       : candidate vector
//   ptr       : round-robin start index (must be < N)
//   rr_en     : 0 = lowest index wins, 1 = first set index at/after ptr (wrapping)
//   gnt_id    : index of the winner (0 when nothing is set)
//   gnt_valid : at least one candidate present
module evt_rr_arbiter #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            rr_en,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid
);

    int unsigned w_idx;

    // Scan from the lowest-priority slot towards the highest so that the
    // last hit written is the winner.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        w_idx     = 0;
        for (int unsigned k = N; k > 0; k--) begin
            if (rr_en) begin
                w_idx = (32'(ptr) + k - 1) % N;
            end else begin
                w_idx = k - 1;
            end
            if (req[ID_W'(w_idx)]) begin
                gnt_id    = ID_W'(w_idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_event_ctrl.sv
// Timer event controller: latches rising edges on the timer event lines as
// pending, masks and arbitrates them, and presents one event at a time to
// the core over a req/ack handshake. Configured through an APB slave.
//   HCLK, HRESETn            : clock, asynchronous active-low reset
//   PADDR..PENABLE           : APB request (PADDR[3:2] selects register)
//   PRDATA/PREADY/PSLVERR    : APB response (no wait states)
//   evt_i                    : level event lines, synchronous to HCLK
//   irq_req_o / irq_id_o     : request and index of the served event
//   irq_ack_i                : one-cycle acknowledge from the core
module timer_event_ctrl
    import timer_evt_pkg::*;
#(
    parameter  int APB_ADDR_WIDTH = 12,
    parameter  int EVT_CNT        = 4,
    localparam int ID_W           = $clog2(EVT_CNT)
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [EVT_CNT-1:0]        evt_i,
    output logic                      irq_req_o,
    output logic [ID_W-1:0]           irq_id_o,
    input  logic                      irq_ack_i
);

    logic [EVT_CNT-1:0] r_mask;
    logic [EVT_CNT-1:0] r_pend;
    logic [EVT_CNT-1:0] r_evt_q;
    logic [1:0]         r_ctrl;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_req;
    evt_state_e         r_state;

    logic [EVT_CNT-1:0] w_rise;
    logic [EVT_CNT-1:0] w_cand;
    logic [EVT_CNT-1:0] w_ack_clr;
    logic [EVT_CNT-1:0] w_w1c;
    logic               w_misalign;
    logic               w_wr;
    logic               w_served_ack;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_gnt_valid;
    logic [31:0]        w_rdata;
    logic               w_unused_apb;

    // Upper address bits alias; upper write-data bits have no storage.
    assign w_unused_apb = ^{PADDR[APB_ADDR_WIDTH-1:4], PWDATA};

    assign w_rise       = evt_i & ~r_evt_q;
    assign w_cand       = r_pend & r_mask;
    assign w_misalign   = (PADDR[1:0] != 2'b00);
    assign w_wr         = PSEL & PENABLE & PWRITE & ~w_misalign;
    assign w_served_ack = (r_state == REQ) & irq_ack_i;
    assign w_w1c        = (w_wr && PADDR[3:0] == REG_PEND) ? PWDATA[EVT_CNT-1:0] : '0;

    always_comb begin
        w_ack_clr = '0;
        if (w_served_ack) begin
            w_ack_clr[r_id] = 1'b1;
        end
    end

    evt_rr_arbiter #(
        .N(EVT_CNT)
    ) u_arb (
        .req      (w_cand),
        .ptr      (r_rr_ptr),
        .rr_en    (r_ctrl[CTRL_RR_BIT]),
        .gnt_id   (w_gnt_id),
        .gnt_valid(w_gnt_valid)
    );

    // Configuration and pending state. A new rise wins over any clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_evt_q <= '0;
            r_mask  <= '0;
            r_ctrl  <= '0;
            r_pend  <= '0;
        end else begin
            r_evt_q <= evt_i;
            r_pend  <= (r_pend & ~(w_w1c | w_ack_clr)) | w_rise;
            if (w_wr && PADDR[3:0] == REG_MASK) begin
                r_mask <= PWDATA[EVT_CNT-1:0];
            end
            if (w_wr && PADDR[3:0] == REG_CTRL) begin
                r_ctrl <= PWDATA[1:0];
            end
        end
    end

    // Service FSM. Once raised, the request is held until acknowledged,
    // regardless of later mask/enable/W1C changes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_id     <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_ctrl[CTRL_EN_BIT] && w_gnt_valid) begin
                        r_id    <= w_gnt_id;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack_i) begin
                        r_req    <= 1'b0;
                        r_rr_ptr <= (r_id == ID_W'(EVT_CNT - 1)) ? '0 : r_id + 1'b1;
                        r_state  <= GAP;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (PSEL && !w_misalign) begin
            case (PADDR[3:0])
                REG_MASK: w_rdata[EVT_CNT-1:0] = r_mask;
                REG_PEND: w_rdata[EVT_CNT-1:0] = r_pend;
                REG_CTRL: w_rdata[1:0]         = r_ctrl;
                REG_ID: begin
                    w_rdata[ID_W-1:0] = r_id;
                    w_rdata[31]       = r_req;
                end
                default: w_rdata = '0;
            endcase
        end
    end

    assign PRDATA    = w_rdata;
    assign PREADY    = 1'b1;
    assign PSLVERR   = PSEL & PENABLE & w_misalign;
    assign irq_req_o = r_req;
    assign irq_id_o  = r_id;

endmodule

// File: doc/timer_event_ctrl.md
Name: timer_event_ctrl

Overview:
- Collects the overflow/compare event lines of the timer array: `2*TIMER_CNT` lines, with `irq_o[2k]` and `irq_o[2k+1]` belonging to timer k.
- Latches each event as pending, applies a software mask and arbitrates between pending events.
- Presents one event at a time to the core over a req/ack handshake.
- Has its own APB slave for configuration and status, on the same peripheral bus as the timer block.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width.
- EVT_CNT, 4, number of event inputs (= 2*TIMER_CNT); range 2..32.
- ID_W, $clog2(EVT_CNT), width of the event index (derived, not overridden).

Ports:
- HCLK  in  1  system clock; single clock domain.
- HRESETn  in  1  asynchronous active-low reset.
- PADDR  in  APB_ADDR_WIDTH  APB address; bits [3:2] select the register.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable phase.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied 1; no wait states.
- PSLVERR  out  1  error for unmapped address.
- evt_i  in  EVT_CNT  level event lines, synchronous to HCLK.
- irq_req_o  out  1  interrupt request to core.
- irq_id_o  out  ID_W  index of the event being requested.
- irq_ack_i  in  1  core acknowledge; one-cycle pulse.

Behaviour:
- Reset (HRESETn low, asynchronous) clears all state:
  - registers: MASK=0, PENDING=0, CTRL=0, evt_q=0, rr_ptr=0;
  - FSM=IDLE;
  - outputs: irq_req_o=0, irq_id_o=0, PRDATA=0, PSLVERR=0.
- Edge detect: rise[i] = evt_i[i] & ~evt_q[i]; evt_q is registered every cycle. A level held high produces one event only.
- PENDING[i] set/clear:
  - set on rise[i];
  - cleared by APB W1C, or by ack when the FSM is serving i;
  - set has priority over clear in the same cycle.
- APB access:
  - write commits on PSEL&PENABLE&PWRITE; read data is combinational when PSEL=1, else 0.
  - Upper PRDATA bits above EVT_CNT read 0.
  - 0x0 MASK, RW: bit i=1 enables event i.
  - 0x4 PENDING, R / W1C.
  - 0x8 CTRL, RW: bit0 EN, bit1 RR (0 = fixed priority with lowest index first, 1 = round-robin).
  - 0xC ID, RO: [ID_W-1:0] current id, bit31 = irq_req_o.
  - Address bits above [3:0] are ignored (aliasing). Any access with PADDR[1:0]!=0 gives PSLVERR=1 during the access phase, no write effect, and PRDATA=0.
- Candidates: cand = PENDING & MASK.
- Arbitration:
  - fixed mode: lowest set index of cand;
  - RR mode: first set index at or after rr_ptr, wrapping modulo EVT_CNT.
- FSM states:
  - IDLE: if EN && cand!=0, latch the winner into id_q and go to REQ.
  - REQ: irq_req_o=1, irq_id_o=id_q.
    - id_q is stable for the whole request.
    - Mask, W1C or EN changes do not withdraw the request; the handshake always completes.
    - On irq_ack_i: clear PENDING[id_q] (unless rise on the same cycle), set rr_ptr = id_q+1 mod EVT_CNT, go to GAP.
  - GAP: irq_req_o=0 for exactly one cycle, then IDLE.
- irq_ack_i outside REQ is ignored.
- Latency:
  - rise sampled at edge n -> PENDING bit visible after edge n;
  - FSM leaves IDLE at edge n+1 -> irq_req_o high from edge n+1.
  - Back-to-back service: ack at edge m -> next irq_req_o high after edge m+2.
- irq_id_o holds its last value when irq_req_o=0.

Decomposition:
- Package timer_evt_pkg holds:
  - register offsets (MASK=4'h0, PEND=4'h4, CTRL=4'h8, ID=4'hC);
  - CTRL bit positions;
  - FSM state enum (IDLE, REQ, GAP).
- Sub-module evt_rr_arbiter (params N; inputs req[N], ptr, rr_en; outputs gnt_id, gnt_valid): purely combinational priority/round-robin pick.
- The top level contains the registers, edge detect, FSM and APB decode.

Test Plan:
- Basic service:
  - Stimulus: reset, MASK=0xF, CTRL=1, pulse evt_i[2] for 1 cycle.
  - Response: PENDING reads 0x4; irq_req_o rises 2 edges after the pulse with irq_id_o=2; ack -> PENDING=0, req low for one cycle and stays low.
- Fixed vs round-robin:
  - Stimulus: set evt 0 and 3 pending simultaneously with CTRL=1, serving with acks repeatedly; repeat with CTRL=3 and rr_ptr=1 after serving 0.
  - Response: fixed mode serves 0 then 3; RR with events 0,3 re-raised after the first ack serves 3 before 0.
- Mask and disable:
  - Stimulus: MASK=0x0, evt_i[1] pulse.
  - Response: PENDING=0x2, no request. Writing MASK=0x2 produces a request with id 1. Clearing EN mid-request still holds req until ack.
- Simultaneous set/clear:
  - Stimulus: new rise on the served id in the ack cycle; separately, W1C of 0x1 in the same cycle as rise[0].
  - Response: the bit stays pending in both cases; a second request follows after GAP.
- APB errors and reset:
  - Stimulus: access at 0x2 -> PSLVERR=1, no register change. Assert HRESETn low during REQ.
  - Response: irq_req_o falls immediately (asynchronously); all registers read 0 after reset; a held-high evt_i after reset yields exactly one event.
